// File: rtl/sensor_monitor.sv
// Debounced sensor fault monitor with sticky alarm FSM; SENSOR_MONITOR_SYNC_EN adds a 2-flop input synchroniser.
// Latency: raw input to sensors_f is DEBOUNCE edges (+2 with the synchroniser); error is combinational; latch and count follow 1 edge later.
// Backpressure: none. Inputs are sampled every cycle and the outputs are status levels.
module sensor_monitor #(
    parameter int NUM_SENSORS = 4,
    parameter int DEBOUNCE    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SENSORS-1:0] sensors,
    input  logic                   clear,
    output logic [NUM_SENSORS-1:0] sensors_f,
    output logic                   error,
    output logic                   fault_latched,
    output logic [7:0]             fault_count
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_OK,
        ST_ALARM,
        ST_HOLD
    } state_t;

    logic [NUM_SENSORS-1:0] samp;
    logic [CW-1:0]          cnt [NUM_SENSORS];
    state_t                 state;
    state_t                 state_nxt;
    logic                   count_inc;

`ifdef SENSOR_MONITOR_SYNC_EN
    logic [NUM_SENSORS-1:0] sync1;
    logic [NUM_SENSORS-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sensors;
            sync2 <= sync1;
        end
    end

    assign samp = sync2;
`else
    assign samp = sensors;
`endif

    // A sensor's filtered level only moves after DEBOUNCE consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sensors_f <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (samp[i] == sensors_f[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    sensors_f[i] <= samp[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign error = sensors_f[0] | (sensors_f[1] & (|sensors_f[NUM_SENSORS-1:2]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_inc = 1'b0;
        case (state)
            ST_OK: begin
                if (error) begin
                    state_nxt = ST_ALARM;
                    count_inc = 1'b1;
                end
            end
            ST_ALARM: begin
                if (!error) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A returning fault wins over a simultaneous clear.
                if (error) begin
                    state_nxt = ST_ALARM;
                    count_inc = 1'b1;
                end else if (clear) begin
                    state_nxt = ST_OK;
                end
            end
            default: begin
                state_nxt = ST_OK;
            end
        endcase
    end

    assign fault_latched = (state != ST_OK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_count <= 8'd0;
        end else if (count_inc && (fault_count != 8'hFF)) begin
            fault_count <= fault_count + 8'd1;
        end
    end

endmodule

// File: doc/sensor_monitor.md
# sensor_monitor

Parametrised, debounced sensor fault monitor for `NUM_SENSORS` sensor inputs. Each raw input is filtered by its own persistence counter. The filtered vector is evaluated against a fixed fault rule:
- sensor 0 faults on its own;
- sensor 1 faults when paired with any of sensors 2..N-1.

A three-state alarm FSM latches faults until software clears them and counts fault events. The block sits between the raw sensor pins and the system status/interrupt logic.

## Interface
Parameters:
- `NUM_SENSORS`, 4: number of sensor inputs; legal range ≥ 3.
- `DEBOUNCE`, 4: number of consecutive sampled cycles a sensor must hold a new level before its filtered value changes; legal range ≥ 1.

Ports:
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `sensors`  in  `NUM_SENSORS`: raw sensor levels.
- `clear`  in  1: single-cycle request to clear a latched fault.
- `sensors_f`  out  `NUM_SENSORS`: filtered sensor levels, registered.
- `error`  out  1: live fault, computed from `sensors_f`.
- `fault_latched`  out  1: sticky fault flag, registered.
- `fault_count`  out  8: number of fault events, saturating.

## Operation
- **Reset:** `sensors_f`=0, all debounce counters=0, FSM=OK, `fault_count`=0, synchroniser flops=0. Therefore `error`=0 and `fault_latched`=0.
- **Debounce, per sensor i:**
  - Counter width is $clog2(DEBOUNCE+1).
  - If the sampled input equals `sensors_f[i]`: counter ← 0.
  - Otherwise: counter increments.
  - On the edge where the counter would reach `DEBOUNCE`: `sensors_f[i]` ← input and counter ← 0.
  - Any return to the old level before that edge resets the counter, so no output change occurs.
- **Fault rule:** `error` = `sensors_f[0]` | (`sensors_f[1]` & |`sensors_f[N-1:2]`).
  - `error` is combinational from flops only, so it is glitch-free.
- **FSM states:** OK, ALARM, HOLD. `fault_latched` = (state != OK).
  - OK: `error`=1 → ALARM, and `fault_count` increments.
  - ALARM: `error`=0 → HOLD. `clear` is ignored in ALARM.
  - HOLD: `error`=1 → ALARM, and `fault_count` increments. This takes priority over `clear` in the same cycle.
  - HOLD: `clear`=1 with `error`=0 → OK.
- **Fault count:** `fault_count` saturates at 255; further fault events leave it at 255.

## Timing
- **Raw input to `sensors_f`:** a raw input held stable at its new level across `DEBOUNCE` consecutive rising edges updates `sensors_f` on the `DEBOUNCE`-th edge.
  - With `DEBOUNCE`=1, `sensors_f` follows the input with a 1-cycle delay.
- **`sensors_f` to `error`:** 0 cycles.
- **`error` to `fault_latched`/`fault_count`:** both update on the first edge on which `error`=1, i.e. 1 cycle after `error` rises.
- **`clear` in HOLD:** `fault_latched` falls on the same edge that samples `clear`.
- **Reset mid-operation:** all state returns to reset values immediately, without waiting for `clk`.
  - Partially accumulated debounce counts are discarded.
  - `fault_count` is lost.
- **Simultaneous changes:** sensors change independently. Multiple sensors crossing their thresholds on the same edge are evaluated together in the new `sensors_f`.

## Configuration
- `SENSOR_MONITOR_SYNC_EN` defined:
  - A 2-flop synchroniser, reset to 0, is inserted on every `sensors` bit ahead of the debounce logic.
  - All input-to-output latencies above increase by exactly 2 cycles.
- `SENSOR_MONITOR_SYNC_EN` undefined:
  - `sensors` feeds the debounce logic directly.
  - Inputs must be synchronous to `clk`.

## Test plan
Default parameters (N=4, D=4), macro undefined unless stated.
- **Reset:** assert `rst` with `sensors`=4'b1111 → `sensors_f`=0, `error`=0, `fault_latched`=0, `fault_count`=0; all hold while `rst`=1.
- **Debounce:**
  - `sensors`=4'b0001 held → `sensors_f`=4'b0001 and `error`=1 after edge 4; `fault_latched`=1 and `fault_count`=1 after edge 5.
  - A 3-cycle pulse on sensor 0 → no output change.
- **Fault rule:**
  - 4'b0110 and 4'b1010 stable → `error`=1.
  - 4'b0010, 4'b1100 and 4'b0100 → `error`=0.
- **Latch and clear:**
  - After a fault, drive `sensors`=0; `clear` pulsed in ALARM → ignored.
  - Once in HOLD, `clear` → `fault_latched`=0 on that edge.
  - Re-fault from HOLD with `clear`=1 in the same cycle → stays latched, `fault_count`=2.
- **Saturation and reset:**
  - 260 fault/clear cycles → `fault_count`=255.
  - Assert `rst` after 2 of 4 debounce cycles, then release and hold the input → `sensors_f` updates only after 4 further edges.
- **Sync build:** with `SENSOR_MONITOR_SYNC_EN` defined, repeat the debounce scenario → `error` after edge 6, `fault_latched` after edge 7.
